// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the matrix keypad scanner:
//   ScanState_t : scanner FSM states (SCAN, DEBOUNCE, HELD, RELEASE)
//   keyCode()   : maps a (row, column) position to its key code
// No ports; imported by keypad_scanner.
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } ScanState_t;

  // Codes are numbered from 1 in row-major order, and the last key in the
  // matrix wraps round to 0, so a 4x4 pad fits a 4-bit code exactly.
  function automatic int keyCode(input int row, input int col,
                                 input int rows, input int cols);
    return (row * cols + col + 1) % (rows * cols);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
// Key delivery handshake between the scanner and its consumer.
//   key_code    : encoded key, held stable while key_valid is 1
//   key_valid   : key_code holds a key the consumer has not yet taken
//   key_ready   : consumer takes key_code when key_valid & key_ready
//   overrun     : sticky flag, a debounced press was dropped
//   overrun_clr : consumer request to clear overrun
// Modports: master (scanner side), slave (consumer side).
// ---------------------------------------------------------------------------
interface keypad_scanner_if #(
  parameter int CW = 4
);

  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;
  logic          overrun;
  logic          overrun_clr;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ready,
    input  overrun_clr
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ready,
    output overrun_clr
  );

endinterface

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Parametrised-width two-flop synchronizer with synchronous reset.
//   clock : sampling clock
//   reset : synchronous active-high reset, clears both stages
//   d     : asynchronous input bus
//   q     : synchronized copy of d, two clocks late
// ---------------------------------------------------------------------------
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First stage may go metastable; the second stage gives it a full cycle
  // to settle before anything downstream looks at the value. Clearing to
  // zero right after reset is harmless for the scanner, because it only
  // samples rows at the end of a dwell, long after both stages have refilled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a ROWS x COLS matrix keypad one column at a time, debounces press
// and release, and delivers one key code per press over a valid/ready
// handshake, flagging presses that arrive while a key is still pending.
//   clock     : system clock, all logic on its rising edge
//   reset     : synchronous active-high reset
//   keyboard  : active-low row sense lines, asynchronous to clock
//   col_drive : active-low one-hot column drive, all-high only in reset
//   bus       : keypad_scanner_if master (key_code/key_valid/key_ready,
//               overrun/overrun_clr)
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ROWS-1:0] keyboard,
  output logic [COLS-1:0] col_drive,
  keypad_scanner_if.master bus
);

  localparam int CW  = $clog2(ROWS * COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CIW = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int BW  = $clog2(DEBOUNCE_CYCLES);

  ScanState_t r_state;
  ScanState_t w_nextState;

  logic [CIW-1:0]  r_col;
  logic [DW-1:0]   r_dwell;
  logic [BW-1:0]   r_cnt;
  logic [ROWS-1:0] r_latchRows;
  logic [RW-1:0]   r_latchRow;
  logic [CW-1:0]   r_keyCode;
  logic            r_keyValid;
  logic            r_overrun;
  logic            r_inReset;

  logic [ROWS-1:0] w_rows;
  logic            w_anyLow;
  logic            w_allHigh;
  logic            w_dwellEnd;
  logic            w_match;
  logic            w_cntLast;
  logic [RW-1:0]   w_lowRow;
  logic [CIW-1:0]  w_colNext;
  logic [CW-1:0]   w_newCode;

  logic            w_emit;
  logic            w_latch;
  logic            w_advance;
  logic            w_cntInc;
  logic            w_dwellInc;

  sync2 #(
    .WIDTH (ROWS)
  ) u_rowSync (
    .clock (clock),
    .reset (reset),
    .d     (keyboard),
    .q     (w_rows)
  );

  assign w_anyLow   = ~&w_rows;
  assign w_allHigh  = &w_rows;
  assign w_dwellEnd = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_match    = (w_rows == r_latchRows);
  assign w_cntLast  = (r_cnt == BW'(DEBOUNCE_CYCLES - 1));
  assign w_colNext  = (r_col == CIW'(COLS - 1)) ? '0 : r_col + CIW'(1);
  assign w_newCode  = CW'(keyCode(int'(r_latchRow), int'(r_col), ROWS, COLS));

  // Lowest-index active row wins when several rows on the driven column
  // are low together; scanning downwards lets the lowest index overwrite.
  always_comb begin
    w_lowRow = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!w_rows[i]) begin
        w_lowRow = RW'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state logic. A press is only looked for on the last cycle of
  // a column's dwell, when the synchronizer has long since caught up with
  // the newly driven column. The counter compare against DEBOUNCE_CYCLES-1
  // means the transition fires on the DEBOUNCE_CYCLES-th qualifying cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SCAN: begin
        if (w_dwellEnd && w_anyLow) begin
          w_nextState = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!w_match) begin
          w_nextState = SCAN;
        end else if (w_cntLast) begin
          w_nextState = HELD;
        end
      end
      HELD: begin
        if (w_allHigh) begin
          w_nextState = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_allHigh) begin
          w_nextState = HELD;
        end else if (w_cntLast) begin
          w_nextState = SCAN;
        end
      end
      default: w_nextState = SCAN;
    endcase
  end

  // FSM outputs: per-state control strobes for the datapath registers.
  // Counters increment only while their qualifying condition holds and
  // clear on the cycle they complete, so they never reach a wrap point.
  always_comb begin
    w_emit     = 1'b0;
    w_latch    = 1'b0;
    w_advance  = 1'b0;
    w_cntInc   = 1'b0;
    w_dwellInc = 1'b0;
    case (r_state)
      SCAN: begin
        w_dwellInc = !w_dwellEnd;
        w_latch    = w_dwellEnd && w_anyLow;
        w_advance  = w_dwellEnd && !w_anyLow;
      end
      DEBOUNCE: begin
        w_emit    = w_match && w_cntLast;
        w_cntInc  = w_match && !w_cntLast;
        w_advance = !w_match;
      end
      RELEASE: begin
        w_cntInc  = w_allHigh && !w_cntLast;
        w_advance = w_allHigh && w_cntLast;
      end
      default: begin
      end
    endcase
  end

  // Scan datapath: dwell timer, shared debounce/release counter, column
  // index, and the row pattern and winning row captured at detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col       <= '0;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_latchRows <= '1;
      r_latchRow  <= '0;
    end else begin
      r_dwell <= w_dwellInc ? r_dwell + DW'(1) : '0;
      r_cnt   <= w_cntInc ? r_cnt + BW'(1) : '0;
      if (w_advance) begin
        r_col <= w_colNext;
      end
      if (w_latch) begin
        r_latchRows <= w_rows;
        r_latchRow  <= w_lowRow;
      end
    end
  end

  // Key delivery. A new key is accepted if the slot is empty or is being
  // emptied this very cycle; otherwise the key is dropped and overrun set.
  // A drop in the same cycle as overrun_clr leaves overrun set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_keyCode  <= '0;
      r_keyValid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_emit && (!r_keyValid || bus.key_ready)) begin
        r_keyValid <= 1'b1;
        r_keyCode  <= w_newCode;
      end else if (r_keyValid && bus.key_ready) begin
        r_keyValid <= 1'b0;
      end
      if (w_emit && r_keyValid && !bus.key_ready) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Registered reset indicator, so col_drive goes all-high exactly for the
  // cycles following a sampled reset and column 0 is driven from the first
  // cycle after release, with no path from an input to the outputs.
  always_ff @(posedge clock) begin
    r_inReset <= reset;
  end

  assign col_drive     = r_inReset ? '1 : ~(COLS'(1) << r_col);
  assign bus.key_code  = r_keyCode;
  assign bus.key_valid = r_keyValid;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_CYCLES=16. A 4x4
// instance is driven by a switch-matrix model of the pad; a second 2x8
// instance covers the non-square geometry.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] keyboard;
  logic [3:0] colDrive;
  logic [1:0] keyboard2;
  logic [7:0] colDrive2;

  logic [3:0] pressed  [4];
  logic [7:0] pressed2 [2];

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int hsCount = 0;
  int expQ[$];
  logic rstSampled = 1'b1;
  logic prevValidPending = 1'b0;
  logic prevOverrunHold  = 1'b0;
  logic [3:0] prevCode = '0;

  keypad_scanner_if #(.CW(4)) bus ();
  keypad_scanner_if #(.CW(4)) bus2 ();

  keypad_scanner #(
    .ROWS (4), .COLS (4), .SCAN_DIV (8), .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .keyboard  (keyboard),
    .col_drive (colDrive),
    .bus       (bus)
  );

  keypad_scanner #(
    .ROWS (2), .COLS (8), .SCAN_DIV (8), .DEBOUNCE_CYCLES (16)
  ) dut2 (
    .clock     (clock),
    .reset     (reset),
    .keyboard  (keyboard2),
    .col_drive (colDrive2),
    .bus       (bus2)
  );

  always #5 clock = ~clock;

  // Switch matrix: a row reads low when any pressed switch on it sits on
  // the column currently driven low.
  always_comb begin
    keyboard = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && !colDrive[c]) keyboard[r] = 1'b0;
      end
    end
  end

  always_comb begin
    keyboard2 = '1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (pressed2[r][c] && !colDrive2[c]) keyboard2[r] = 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    cycle      <= cycle + 1;
    rstSampled <= reset;
  end

  // Key numbering rule: row-major from 1, last key wraps to 0.
  function automatic int modelCode(input int r, input int c, input int rows, input int cols);
    int n;
    n = r * cols + c + 1;
    if (n == rows * cols) n = 0;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Per-cycle compare against the model: reset values after a sampled
  // reset, otherwise one-hot column drive, a pending key holding still,
  // sticky overrun, and every delivered key matching the expected queue.
  always @(negedge clock) begin
    if (rstSampled) begin
      checkOutput("reset col_drive", colDrive, 4'hF);
      checkOutput("reset key_valid", bus.key_valid, 0);
      checkOutput("reset key_code", bus.key_code, 0);
      checkOutput("reset overrun", bus.overrun, 0);
      expQ.delete();
      prevValidPending = 1'b0;
      prevOverrunHold  = 1'b0;
    end else begin
      checkOutput("col_drive one-hot", $countones(~colDrive), 1);
      if (prevValidPending) begin
        checkOutput("pending key_valid held", bus.key_valid, 1);
        checkOutput("pending key_code stable", bus.key_code, prevCode);
      end
      if (prevOverrunHold) checkOutput("overrun sticky", bus.overrun, 1);
      if (bus.key_valid && bus.key_ready && !reset) begin
        hsCount++;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected key: got code %0d expected none", bus.key_code);
        end else begin
          checkOutput("delivered key_code", bus.key_code, expQ.pop_front());
        end
      end
      prevValidPending = bus.key_valid && !bus.key_ready && !reset;
      prevOverrunHold  = bus.overrun && !bus.overrun_clr && !reset;
      prevCode         = bus.key_code;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic v);
    pressed[r][c] = v;
  endtask

  task automatic waitValid(input int maxCycles, input string name);
    int n = 0;
    while (!bus.key_valid && n < maxCycles) begin
      waitCycles(1);
      n++;
    end
    checkOutput(name, bus.key_valid, 1);
  endtask

  task automatic waitValid2(input int maxCycles, input string name);
    int n = 0;
    while (!bus2.key_valid && n < maxCycles) begin
      waitCycles(1);
      n++;
    end
    checkOutput(name, bus2.key_valid, 1);
  endtask

  task automatic pressCheck(input int r, input int c, input int lit, input string name);
    expQ.push_back(modelCode(r, c, 4, 4));
    applyStimulus(r, c, 1'b1);
    waitValid(200, {name, " valid"});
    checkOutput({name, " code"}, bus.key_code, lit);
    waitCycles(5);
    applyStimulus(r, c, 1'b0);
    waitCycles(60);
  endtask

  task automatic pulseReset(input string name);
    reset = 1'b1;
    waitCycles(1);
    checkOutput({name, " col_drive high"}, colDrive, 4'hF);
    checkOutput({name, " key_valid"}, bus.key_valid, 0);
    checkOutput({name, " key_code"}, bus.key_code, 0);
    checkOutput({name, " overrun"}, bus.overrun, 0);
    for (int r = 0; r < 4; r++) pressed[r] = '0;
    reset = 1'b0;
    waitCycles(1);
    checkOutput({name, " col0 after release"}, colDrive, 4'b1110);
  endtask

  initial begin
    int hs0;
    int t0;
    int n;
    reset = 1'b1;
    bus.key_ready    = 1'b1;
    bus.overrun_clr  = 1'b0;
    bus2.key_ready   = 1'b1;
    bus2.overrun_clr = 1'b0;
    for (int r = 0; r < 4; r++) pressed[r] = '0;
    for (int r = 0; r < 2; r++) pressed2[r] = '0;

    waitCycles(3);
    checkOutput("init col_drive", colDrive, 4'hF);
    checkOutput("init key_valid", bus.key_valid, 0);
    checkOutput("init overrun", bus.overrun, 0);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("init col0 after release", colDrive, 4'b1110);
    waitCycles(40);

    $display("[TB] single press r1c2 with key_ready=1");
    hs0 = hsCount;
    expQ.push_back(modelCode(1, 2, 4, 4));
    applyStimulus(1, 2, 1'b1);
    waitValid(200, "r1c2 valid");
    checkOutput("r1c2 code", bus.key_code, 7);
    waitCycles(100);
    checkOutput("r1c2 one pulse while held", hsCount - hs0, 1);
    applyStimulus(1, 2, 1'b0);
    waitCycles(60);
    checkOutput("r1c2 none after release", hsCount - hs0, 1);
    expQ.push_back(modelCode(1, 2, 4, 4));
    applyStimulus(1, 2, 1'b1);
    waitValid(200, "r1c2 re-press valid");
    checkOutput("r1c2 re-press code", bus.key_code, 7);
    waitCycles(20);
    applyStimulus(1, 2, 1'b0);
    waitCycles(60);
    checkOutput("r1c2 two pulses total", hsCount - hs0, 2);

    $display("[TB] bouncing r2c0");
    hs0 = hsCount;
    for (int p = 0; p < 12; p++) begin
      applyStimulus(2, 0, (p % 2) == 0);
      waitCycles(5);
    end
    checkOutput("bounce no emission", hsCount - hs0, 0);
    expQ.push_back(modelCode(2, 0, 4, 4));
    applyStimulus(2, 0, 1'b1);
    t0 = cycle;
    waitValid(200, "bounce valid");
    checkOutput("bounce code", bus.key_code, 9);
    checkOutput("bounce waited 16 stable", (cycle - t0) >= 16, 1);
    waitCycles(5);
    applyStimulus(2, 0, 1'b0);
    waitCycles(60);
    checkOutput("bounce single emission", hsCount - hs0, 1);

    $display("[TB] overrun with key_ready=0");
    bus.key_ready = 1'b0;
    expQ.push_back(modelCode(0, 0, 4, 4));
    applyStimulus(0, 0, 1'b1);
    waitValid(200, "r0c0 valid");
    checkOutput("r0c0 code", bus.key_code, 1);
    waitCycles(5);
    applyStimulus(0, 0, 1'b0);
    waitCycles(60);
    checkOutput("no overrun yet", bus.overrun, 0);
    applyStimulus(3, 3, 1'b1);
    n = 0;
    while (!bus.overrun && n < 200) begin
      waitCycles(1);
      n++;
    end
    checkOutput("overrun set", bus.overrun, 1);
    checkOutput("overrun key_code kept", bus.key_code, 1);
    applyStimulus(3, 3, 1'b0);
    waitCycles(60);
    bus.overrun_clr = 1'b1;
    waitCycles(1);
    bus.overrun_clr = 1'b0;
    checkOutput("overrun cleared", bus.overrun, 0);
    checkOutput("after clear key_code", bus.key_code, 1);
    checkOutput("after clear key_valid", bus.key_valid, 1);
    bus.key_ready = 1'b1;
    waitCycles(3);
    checkOutput("after accept key_valid", bus.key_valid, 0);

    $display("[TB] code map and multi-row");
    pressCheck(3, 3, 0, "r3c3");
    pressCheck(0, 3, 4, "r0c3");
    pressCheck(3, 0, 13, "r3c0");
    expQ.push_back(modelCode(1, 1, 4, 4));
    applyStimulus(1, 1, 1'b1);
    applyStimulus(3, 1, 1'b1);
    waitValid(200, "r1+r3 c1 valid");
    checkOutput("r1+r3 c1 code", bus.key_code, 6);
    waitCycles(5);
    applyStimulus(1, 1, 1'b0);
    applyStimulus(3, 1, 1'b0);
    waitCycles(60);

    $display("[TB] reset during DEBOUNCE");
    hs0 = hsCount;
    applyStimulus(0, 0, 1'b1);
    n = 0;
    while (colDrive == 4'b1110 && n < 100) begin
      waitCycles(1);
      n++;
    end
    n = 0;
    while (colDrive != 4'b1110 && n < 100) begin
      waitCycles(1);
      n++;
    end
    checkOutput("reach column 0", colDrive, 4'b1110);
    waitCycles(12);
    checkOutput("column 0 held in debounce", colDrive, 4'b1110);
    pulseReset("debounce reset");
    waitCycles(60);
    checkOutput("debounce reset no emission", hsCount - hs0, 0);

    $display("[TB] reset during HELD with pending key");
    bus.key_ready = 1'b0;
    expQ.push_back(modelCode(2, 1, 4, 4));
    applyStimulus(2, 1, 1'b1);
    waitValid(200, "r2c1 valid");
    checkOutput("r2c1 code", bus.key_code, 10);
    waitCycles(5);
    pulseReset("held reset");
    waitCycles(60);
    checkOutput("held reset key discarded", bus.key_valid, 0);
    bus.key_ready = 1'b1;
    waitCycles(5);
    checkOutput("held reset no delivery", hsCount - hs0, 0);
    checkOutput("expected queue drained", expQ.size(), 0);

    $display("[TB] 2x8 geometry");
    pressed2[1][7] = 1'b1;
    waitValid2(300, "2x8 r1c7 valid");
    checkOutput("2x8 r1c7 code", bus2.key_code, 0);
    waitCycles(5);
    pressed2[1][7] = 1'b0;
    waitCycles(60);
    pressed2[0][0] = 1'b1;
    waitValid2(300, "2x8 r0c0 valid");
    checkOutput("2x8 r0c0 code", bus2.key_code, 1);
    waitCycles(5);
    pressed2[0][0] = 1'b0;
    waitCycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of row inputs, 2..8.
REQ-002 Parameter COLS, default 4: number of column outputs, 2..8.
REQ-003 Parameter SCAN_DIV, default 1000: clock cycles each column is driven (dwell), >= 4.
REQ-004 Parameter DEBOUNCE_CYCLES, default 5000: consecutive stable cycles required for press/release, >= 2.
REQ-005 Localparam CW = clog2(ROWS*COLS): key code width.
REQ-006 clock  in  1  single system clock; all logic on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 keyboard  in  ROWS  row sense lines, active-low, asynchronous to clock.
REQ-009 col_drive  out  COLS  column drive, active-low one-hot; all-high only during reset.
REQ-010 key_code  out  CW  encoded key, stable while key_valid=1.
REQ-011 key_valid  out  1  key_code holds an unconsumed key.
REQ-012 key_ready  in  1  consumer accepts key_code when key_valid and key_ready are both 1.
REQ-013 overrun  out  1  sticky: a debounced press was lost because key_valid was still pending.
REQ-014 overrun_clr  in  1  clears overrun.

Function
REQ-015 keyboard SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-016 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-017 SCAN: column index advances every SCAN_DIV cycles, wrapping COLS-1 -> 0; any synchronized row low at the last dwell cycle -> latch column and lowest-index low row, go DEBOUNCE, column held.
REQ-018 DEBOUNCE: counter counts cycles where row pattern equals latched pattern; any mismatch -> SCAN (column continues from next index); count reaches DEBOUNCE_CYCLES -> emit key, go HELD.
REQ-019 Key code SHALL be (row*COLS + col + 1) mod (ROWS*COLS); for 4x4: r0c0=1, r0c3=4, r3c0=13, r3c3=0.
REQ-020 Emit: if key_valid=0 or accepted same cycle, key_code/key_valid update next cycle; else key dropped, overrun set next cycle.
REQ-021 key_valid SHALL stay 1 and key_code unchanged until handshake; cleared the cycle after key_valid&key_ready.
REQ-022 HELD: column stays driven; all rows high -> RELEASE; no repeat emission while held.
REQ-023 RELEASE: counts consecutive all-high cycles; any low row -> HELD with counter cleared; count reaches DEBOUNCE_CYCLES -> SCAN at next column.
REQ-024 Multiple rows low on one column: lowest row index wins; keys on other columns ignored until RELEASE completes.
REQ-025 overrun_clr and a simultaneous new overrun event: set wins.
REQ-026 Counters SHALL saturate/clear exactly; no wrap-induced false events for any parameter value in range.

Reset
REQ-027 On reset=1 at a clock edge: state=SCAN, column index 0, col_drive all-high, key_code=0, key_valid=0, overrun=0, counters and synchronizer cleared.
REQ-028 First cycle after reset release col_drive SHALL drive column 0 (bit0 low).
REQ-029 Reset mid-operation (any state, pending key) SHALL discard the pending key with no emission.

Structure
REQ-030 Package keypad_pkg SHALL hold the FSM state enum and the key-code function.
REQ-031 One sub-module sync2 (parametrised-width 2-flop synchronizer, synchronous reset) SHALL be instantiated for keyboard.
REQ-032 Estimated RTL 150-300 lines; no latches, no combinational path from keyboard to any output.

Verification (bench uses SCAN_DIV=8, DEBOUNCE_CYCLES=16)
REQ-033 Press r1c2 held 100 cycles, key_ready=1 -> exactly one key_valid pulse, key_code=7; none again until release+re-press.
REQ-034 Bounce: r2c0 toggles every 5 cycles for 60 cycles then stable low -> single emission code 9 only after 16 stable cycles.
REQ-035 key_ready=0, press r0c0 then r3c3 -> key_code=1 held, overrun=1; overrun_clr pulse -> overrun=0, key_code still 1.
REQ-036 Rows 1 and 3 low together on c1 -> key_code=6.
REQ-037 Reset asserted in DEBOUNCE and in HELD with pending key -> all outputs at reset values, col_drive=all-high, then bit0 low next cycle.
REQ-038 Parameter sweep ROWS=2,COLS=8: r1c7 -> key_code=0; r0c0 -> key_code=1.
